// File: rtl/bid_arbiter.sv
// bid_arbiter: bidding arbiter from NM bus masters onto one slave port, round-robin tie-break.
// Optional macro AGING_EN adds per-master bid aging so low bidders cannot starve.
module bid_arbiter #(
   parameter int NM        = 4,
   parameter int BIDW      = 4,
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int MAX_XFR   = 16,
   parameter int GRANT_TMO = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NM*BIDW-1:0]    m_req_i,
   output logic [NM-1:0]         m_grant_o,
   input  logic [NM-1:0]         m_xfr_i,
   input  logic [NM-1:0]         m_rw_i,
   input  logic [NM*AW-1:0]      m_addr_i,
   input  logic [NM*DW-1:0]      m_wdata_i,
   output logic [NM*DW-1:0]      m_rdata_o,
   output logic                  s_xfr_o,
   output logic                  s_rw_o,
   output logic [AW-1:0]         s_addr_o,
   output logic [DW-1:0]         s_wdata_o,
   input  logic [DW-1:0]         s_rdata_i,
   output logic [$clog2(NM)-1:0] owner_o,
   output logic                  busy_o
);
   localparam int OW = $clog2(NM);
   localparam int CW = $clog2(MAX_XFR + 1);
   localparam int TW = $clog2(GRANT_TMO + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_BUSY  = 2'd2
   } state_t;

   state_t          state_q;
   logic [NM-1:0]   grant_q;
   logic [OW-1:0]   owner_q;
   logic [OW-1:0]   rr_q;
   logic            busy_q;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   cnt_d;
   logic [TW-1:0]   tmo_q;

   logic [BIDW-1:0] eff_s [NM];
   logic [BIDW-1:0] best_s;
   logic [OW-1:0]   win_s;
   logic [OW-1:0]   idx_s;
   logic            any_s;
   logic            own_xfr_s;
   logic            own_bid_zero_s;

`ifdef AGING_EN
   logic [BIDW-1:0] age_q [NM];
   logic [BIDW-1:0] age_d [NM];
   logic [BIDW:0]   sum_s [NM];

   // Effective bid = raw bid plus age, saturated; a zero bid stays zero
   always_comb begin
      for (int i = 0; i < NM; i++) begin
         sum_s[i] = {1'b0, m_req_i[i*BIDW +: BIDW]} + {1'b0, age_q[i]};
         if (m_req_i[i*BIDW +: BIDW] == {BIDW{1'b0}}) begin
            eff_s[i] = {BIDW{1'b0}};
         end else if (sum_s[i][BIDW]) begin
            eff_s[i] = {BIDW{1'b1}};
         end else begin
            eff_s[i] = sum_s[i][BIDW-1:0];
         end
      end
   end

   // Losers of an arbitration age up, the winner and idle masters clear
   always_comb begin
      for (int i = 0; i < NM; i++) begin
         if (m_req_i[i*BIDW +: BIDW] == {BIDW{1'b0}}) begin
            age_d[i] = {BIDW{1'b0}};
         end else if (state_q == ST_IDLE && any_s) begin
            if (win_s == OW'(i)) begin
               age_d[i] = {BIDW{1'b0}};
            end else if (age_q[i] == {BIDW{1'b1}}) begin
               age_d[i] = age_q[i];
            end else begin
               age_d[i] = age_q[i] + 1'b1;
            end
         end else begin
            age_d[i] = age_q[i];
         end
      end
   end

   // Age register bank
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NM; i++) age_q[i] <= {BIDW{1'b0}};
      end else begin
         for (int i = 0; i < NM; i++) age_q[i] <= age_d[i];
      end
   end
`else
   // Without aging the raw bid is the effective bid
   always_comb begin
      for (int i = 0; i < NM; i++) eff_s[i] = m_req_i[i*BIDW +: BIDW];
   end
`endif

   // Scan from rr_q upward; strict compare keeps the first tied index
   always_comb begin
      best_s = {BIDW{1'b0}};
      win_s  = {OW{1'b0}};
      idx_s  = {OW{1'b0}};
      any_s  = 1'b0;
      for (int k = 0; k < NM; k++) begin
         idx_s = OW'((int'(rr_q) + k) % NM);
         if (eff_s[idx_s] > best_s) begin
            best_s = eff_s[idx_s];
            win_s  = idx_s;
            any_s  = 1'b1;
         end else begin
            best_s = best_s;
         end
      end
   end

   assign own_xfr_s      = m_xfr_i[owner_q];
   assign own_bid_zero_s = (m_req_i[int'(owner_q)*BIDW +: BIDW] == {BIDW{1'b0}});
   assign cnt_d          = cnt_q + 1'b1;

   // Tenure FSM with registered grant/owner/busy
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         grant_q <= {NM{1'b0}};
         owner_q <= {OW{1'b0}};
         rr_q    <= {OW{1'b0}};
         busy_q  <= 1'b0;
         cnt_q   <= {CW{1'b0}};
         tmo_q   <= {TW{1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (any_s) begin
                  state_q <= ST_GRANT;
                  grant_q <= {{(NM-1){1'b0}}, 1'b1} << win_s;
                  owner_q <= win_s;
                  rr_q    <= (win_s == OW'(NM-1)) ? {OW{1'b0}} : win_s + 1'b1;
                  busy_q  <= 1'b1;
                  cnt_q   <= {CW{1'b0}};
                  tmo_q   <= {TW{1'b0}};
               end
            end
            ST_GRANT: begin
               if (own_xfr_s) begin
                  state_q <= ST_BUSY;
                  cnt_q   <= {{(CW-1){1'b0}}, 1'b1};
               end else if (own_bid_zero_s || tmo_q == TW'(GRANT_TMO-1)) begin
                  state_q <= ST_IDLE;
                  grant_q <= {NM{1'b0}};
                  busy_q  <= 1'b0;
               end else begin
                  tmo_q   <= tmo_q + 1'b1;
               end
            end
            ST_BUSY: begin
               cnt_q <= cnt_d;
               // Forced release once this cycle completes the MAX_XFR-th transfer
               if (!own_xfr_s || cnt_d == CW'(MAX_XFR)) begin
                  state_q <= ST_IDLE;
                  grant_q <= {NM{1'b0}};
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               grant_q <= {NM{1'b0}};
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign m_grant_o = grant_q;
   assign owner_o   = owner_q;
   assign busy_o    = busy_q;

   // Owner-to-slave mux; everything reads zero without a grant
   always_comb begin
      s_xfr_o   = busy_q & grant_q[owner_q] & m_xfr_i[owner_q];
      s_rw_o    = 1'b0;
      s_addr_o  = {AW{1'b0}};
      s_wdata_o = {DW{1'b0}};
      m_rdata_o = {(NM*DW){1'b0}};
      if (busy_q) begin
         s_rw_o    = m_rw_i[owner_q];
         s_addr_o  = m_addr_i[int'(owner_q)*AW +: AW];
         s_wdata_o = m_wdata_i[int'(owner_q)*DW +: DW];
         m_rdata_o[int'(owner_q)*DW +: DW] = s_rdata_i;
      end else begin
         s_rw_o    = 1'b0;
      end
   end
endmodule

// File: tb/tb_bid_arbiter.sv
// tb_bid_arbiter: directed scenarios plus random traffic, checked each cycle against a
// tenure-level reference model of the arbiter.
`timescale 1ns/1ps
module tb_bid_arbiter;
   localparam int NM = 4, BIDW = 4, AW = 32, DW = 32, MAX_XFR = 16, GRANT_TMO = 4;
   localparam int MAXB = (1 << BIDW) - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic [NM*BIDW-1:0] m_req;
   logic [NM-1:0]     m_grant, m_xfr, m_rw;
   logic [NM*AW-1:0]  m_addr;
   logic [NM*DW-1:0]  m_wdata, m_rdata;
   logic              s_xfr, s_rw, busy;
   logic [AW-1:0]     s_addr;
   logic [DW-1:0]     s_wdata, s_rdata;
   logic [1:0]        owner;

   bid_arbiter dut (
      .clk_i(clk), .rst_i(rst), .m_req_i(m_req), .m_grant_o(m_grant), .m_xfr_i(m_xfr),
      .m_rw_i(m_rw), .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_rdata_o(m_rdata),
      .s_xfr_o(s_xfr), .s_rw_o(s_rw), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
      .s_rdata_i(s_rdata), .owner_o(owner), .busy_o(busy)
   );

   always #5 clk = ~clk;

   // stimulus values
   int          bid [NM];
   logic [NM-1:0] xfr_v, rw_v;
   logic [AW-1:0] addr_v [NM];
   logic [DW-1:0] wd_v [NM];
   logic [DW-1:0] rd_v;

   // reference model: phase 0 = no tenure, 1 = granted/waiting, 2 = transferring
   int ph, own, rr, wt, nx;
   int age [NM];

   int ntests = 0, nfail = 0;
   logic last_sxfr;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic apply();
      for (int i = 0; i < NM; i++) begin
         m_req[i*BIDW +: BIDW] = BIDW'(bid[i]);
         m_addr[i*AW +: AW]    = addr_v[i];
         m_wdata[i*DW +: DW]   = wd_v[i];
      end
      m_xfr   = xfr_v;
      m_rw    = rw_v;
      s_rdata = rd_v;
   endtask

   function automatic int eff(input int i);
      int e;
      e = bid[i];
`ifdef AGING_EN
      if (bid[i] != 0) e = (bid[i] + age[i] > MAXB) ? MAXB : bid[i] + age[i];
`endif
      return e;
   endfunction

   task automatic model_reset();
      ph = 0; own = 0; rr = 0; wt = 0; nx = 0;
      for (int i = 0; i < NM; i++) age[i] = 0;
   endtask

   task automatic model_update();
      int w, best, p0;
      w = -1; best = 0; p0 = ph;
      if (rst) begin
         model_reset();
         return;
      end
      case (ph)
         0: begin
            for (int i = 0; i < NM; i++) if (eff(i) > best) best = eff(i);
            if (best > 0)
               for (int d = 0; d < NM; d++)
                  if (w < 0 && eff((rr + d) % NM) == best) w = (rr + d) % NM;
         end
         1: begin
            if (xfr_v[own]) begin ph = 2; nx = 1; end
            else if (bid[own] == 0) ph = 0;
            else begin wt++; if (wt == GRANT_TMO) ph = 0; end
         end
         2: begin
            if (!xfr_v[own]) ph = 0;
            else begin nx++; if (nx == MAX_XFR) ph = 0; end
         end
         default: ph = 0;
      endcase
`ifdef AGING_EN
      for (int i = 0; i < NM; i++) begin
         if (bid[i] == 0) age[i] = 0;
         else if (p0 == 0 && w >= 0) age[i] = (i == w) ? 0 : ((age[i] < MAXB) ? age[i] + 1 : MAXB);
      end
`endif
      if (w >= 0) begin own = w; rr = (w + 1) % NM; ph = 1; wt = 0; end
   endtask

   // one clock: drive, check mid-cycle against the model, step the model at the edge
   task automatic tick();
      logic [127:0] er;
      logic         be;
      apply();
      #4;
      be = (ph != 0);
      chk("busy", busy, be);
      chk("grant", m_grant, be ? (128'd1 << own) : 128'd0);
      if (be) chk("owner", owner, own);
      chk("s_xfr", s_xfr, be && xfr_v[own]);
      chk("s_rw", s_rw, be && rw_v[own]);
      chk("s_addr", s_addr, be ? addr_v[own] : 32'd0);
      chk("s_wdata", s_wdata, be ? wd_v[own] : 32'd0);
      er = 128'd0;
      if (be) er[own*DW +: DW] = rd_v;
      chk("m_rdata", m_rdata, er);
      last_sxfr = s_xfr;
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic clear_bids();
      for (int i = 0; i < NM; i++) bid[i] = 0;
      xfr_v = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_bids();
      model_reset();
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int n;
      logic [NM-1:0] exp6;
      rst = 1'b1;
      rw_v = 4'b1010;
      rd_v = 32'hCAFE_0001;
      for (int i = 0; i < NM; i++) begin
         addr_v[i] = 32'h1000_0000 + 32'(i);
         wd_v[i]   = 32'hD000_0000 + 32'(i);
      end
      clear_bids();
      model_reset();
      apply();

      // reset state
      do_reset();
      chk("rst_grant", m_grant, 4'b0000);
      chk("rst_owner", owner, 2'd0);
      chk("rst_busy", busy, 1'b0);

      // highest bid wins
      bid[0] = 3; bid[1] = 9; bid[2] = 0; bid[3] = 5;
      tick();
      chk("t1_grant", m_grant, 4'b0010);
      chk("t1_owner", owner, 2'd1);
      chk("t1_busy", busy, 1'b1);
      clear_bids();
      tick(); tick();

      // tie resolved round-robin
      do_reset();
      bid[0] = 7; bid[2] = 7;
      tick();
      chk("t2_first", m_grant, 4'b0001);
      xfr_v[0] = 1'b1; tick();
      xfr_v = '0; tick();
      tick();
      chk("t2_second", m_grant, 4'b0100);
      clear_bids(); tick(); tick();

      // forced release after MAX_XFR transfers; owner bid drop ignored mid-tenure
      do_reset();
      bid[1] = 1;
      tick();
      chk("t3_grant", m_grant, 4'b0010);
      bid[1] = 0; xfr_v[1] = 1'b1; n = 0;
      repeat (20) begin
         tick();
         if (last_sxfr) n++;
      end
      chk("t3_sxfr_cycles", n, 16);
      chk("t3_grant_off", m_grant, 4'b0000);
      clear_bids(); tick();

      // grant timeout without xfr
      do_reset();
      bid[3] = 5;
      tick();
      chk("t4_grant", m_grant, 4'b1000);
      tick(); tick(); tick();
      chk("t4_still", m_grant, 4'b1000);
      tick();
      chk("t4_drop", m_grant, 4'b0000);
      clear_bids(); tick(); tick();

      // asynchronous reset mid-BUSY, then rr_ptr back at 0
      do_reset();
      bid[1] = 4;
      tick();
      xfr_v[1] = 1'b1; tick(); tick();
      chk("t5_pre_sxfr", s_xfr, 1'b1);
      #1 rst = 1'b1;
      #1;
      chk("t5_grant", m_grant, 4'b0000);
      chk("t5_sxfr", s_xfr, 1'b0);
      chk("t5_busy", busy, 1'b0);
      model_reset();
      clear_bids();
      @(posedge clk); #1;
      rst = 1'b0;
      bid[0] = 7; bid[3] = 7;
      tick();
      chk("t5_rr", m_grant, 4'b0001);
      clear_bids(); tick(); tick();

      // aging scenario
      do_reset();
      bid[0] = 2; bid[1] = 5;
      for (int a = 1; a <= 4; a++) begin
`ifdef AGING_EN
         exp6 = (a == 4) ? 4'b0001 : 4'b0010;
`else
         exp6 = 4'b0010;
`endif
         tick();
         chk($sformatf("t6_arb%0d", a), m_grant, exp6);
         if (m_grant[1]) begin
            xfr_v[1] = 1'b1; tick();
            xfr_v = '0; tick();
         end
      end
      clear_bids(); tick(); tick(); tick();

      // randomized traffic
      do_reset();
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < NM; i++) begin
            if ($urandom_range(0, 3) == 0)
               bid[i] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, MAXB));
            addr_v[i] = $urandom;
            wd_v[i]   = $urandom;
         end
         xfr_v = NM'($urandom) | (((c / 25) % 2 == 1) ? 4'hF : 4'h0);
         rw_v  = NM'($urandom);
         rd_v  = $urandom;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
